// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM state encoding and CPSR flag layout shared by the seq_alu_v2 slice
package seq_alu_pkg;
    localparam logic [4:0] OP_MOV   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_MULH  = 5'b00011;
    localparam logic [4:0] OP_UMULH = 5'b00100;
    localparam logic [4:0] OP_CMP   = 5'b00101;
    localparam logic [4:0] OP_AND   = 5'b00110;
    localparam logic [4:0] OP_OR    = 5'b00111;
    localparam logic [4:0] OP_NOR   = 5'b01000;
    localparam logic [4:0] OP_NAND  = 5'b01001;
    localparam logic [4:0] OP_XOR   = 5'b01010;
    localparam logic [4:0] OP_XNOR  = 5'b01011;
    localparam logic [4:0] OP_NOT   = 5'b01100;
    localparam logic [4:0] OP_MULL  = 5'b01111;
    localparam logic [4:0] OP_UMULL = 5'b10000;
    localparam logic [4:0] OP_UDIV  = 5'b10100;
    localparam logic [4:0] OP_UREM  = 5'b10101;
    localparam logic [4:0] OP_LSR   = 5'b11000;
    localparam logic [4:0] OP_LSL   = 5'b11001;
    localparam logic [4:0] OP_ASR   = 5'b11010;
    localparam logic [4:0] OP_ROR   = 5'b11100;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;
endpackage

// File: rtl/seq_alu_v2_if.sv
// seq_alu_v2_if: operation request / result handshake bundle for seq_alu_v2
interface seq_alu_v2_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             cout;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, opcode, x, y, out_ready,
        input  in_ready, out_valid, r, negative, zero, overflow, cout, illegal, busy
    );

    modport slave (
        input  in_valid, opcode, x, y, out_ready,
        output in_ready, out_valid, r, negative, zero, overflow, cout, illegal, busy
    );
endinterface

// File: rtl/seq_alu_iter_unit.sv
// seq_alu_iter_unit: one-bit-per-cycle shift-add multiplier; restoring divider when SEQ_ALU_DIV_EN is defined
module seq_alu_iter_unit
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_ALU_DIV_EN
    input  logic               div,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc, acc_n, mc, mc_n;
    logic [WIDTH-1:0]   q, q_n;
    logic [CW-1:0]      cnt;
`ifdef SEQ_ALU_DIV_EN
    logic               mode;
    logic [WIDTH:0]     sh, df;
`endif

    // next iteration values; done fires on the final iteration so results are exposed from the next-state view
    always_comb begin
        acc_n = acc + (q[0] ? mc : '0);
        mc_n  = mc << 1;
        q_n   = q >> 1;
`ifdef SEQ_ALU_DIV_EN
        sh = {acc[WIDTH-1:0], q[WIDTH-1]};
        df = sh - {1'b0, mc[WIDTH-1:0]};
        if (mode) begin
            acc_n = {{WIDTH{1'b0}}, df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0]};
            mc_n  = mc;
            q_n   = {q[WIDTH-2:0], ~df[WIDTH]};
        end
`endif
    end

    // load operands on start, then step once per cycle while the counter is nonzero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(WIDTH);
            acc <= '0;
`ifdef SEQ_ALU_DIV_EN
            mode <= div;
            mc   <= {{WIDTH{1'b0}}, div ? b : a};
            q    <= div ? a : b;
`else
            mc   <= {{WIDTH{1'b0}}, a};
            q    <= b;
`endif
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            acc <= acc_n;
            mc  <= mc_n;
            q   <= q_n;
        end
    end

    assign done = cnt == CW'(1);
    assign prod = acc_n;
`ifdef SEQ_ALU_DIV_EN
    assign quo = q_n;
    assign rem = acc_n[WIDTH-1:0];
`endif
endmodule

// File: rtl/seq_alu_v2.sv
// seq_alu_v2: handshaked sequential ALU with CPSR flags; SEQ_ALU_DIV_EN adds UDIV/UREM
module seq_alu_v2
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    seq_alu_v2_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] MUL  = ST_MUL;
    localparam logic [1:0] DIV  = ST_DIV;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]         st;
    logic [WIDTH-1:0]   r_q;
    flags_t             fl_q;
    logic               ill_q, neg_q;
    logic [4:0]         op_q;

    logic [WIDTH:0]     sum, dif, sl, sr;
    logic signed [WIDTH:0] sa;
    logic [WIDTH-1:0]   ror, sres, ax, ay, cr;
    logic [SW-1:0]      amt;
    logic               sv, sc, sdef, smul, sdiv, sg, go, done, cv;
    logic [2*WIDTH-1:0] prod, p;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0]   quo, rem;
    logic               yz_q;
`endif

    assign amt = bus.y[SW-1:0];
    assign sum = {1'b0, bus.x} + {1'b0, bus.y};
    assign dif = {1'b0, bus.x} - {1'b0, bus.y};
    assign sl  = {1'b0, bus.x} << amt;
    assign sr  = {bus.x, 1'b0} >> amt;
    assign sa  = $signed({bus.x, 1'b0}) >>> amt;
    assign ror = (bus.x >> amt) | (bus.x << (WIDTH - int'(amt)));

    // single-cycle result and decode of the offered opcode; the extra low bit of sr/sa catches the last bit out
    always_comb begin
        sres = '0;
        sv   = 1'b0;
        sc   = 1'b0;
        sdef = 1'b1;
        smul = 1'b0;
        sdiv = 1'b0;
        case (bus.opcode)
            OP_MOV:  sres = bus.x;
            OP_ADD: begin
                sres = sum[WIDTH-1:0];
                sc   = sum[WIDTH];
                sv   = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                sres = dif[WIDTH-1:0];
                sc   = ~dif[WIDTH];
                sv   = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (dif[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_AND:  sres = bus.x & bus.y;
            OP_OR:   sres = bus.x | bus.y;
            OP_NOR:  sres = ~(bus.x | bus.y);
            OP_NAND: sres = ~(bus.x & bus.y);
            OP_XOR:  sres = bus.x ^ bus.y;
            OP_XNOR: sres = ~(bus.x ^ bus.y);
            OP_NOT:  sres = ~bus.x;
            OP_LSR: begin
                sres = sr[WIDTH:1];
                sc   = sr[0];
            end
            OP_LSL: begin
                sres = sl[WIDTH-1:0];
                sc   = sl[WIDTH];
            end
            OP_ASR: begin
                sres = sa[WIDTH:1];
                sc   = sa[0];
            end
            OP_ROR: begin
                sres = ror;
                sc   = ror[WIDTH-1];
            end
            OP_MULH, OP_UMULH, OP_MULL, OP_UMULL: smul = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_UDIV, OP_UREM: sdiv = 1'b1;
`endif
            default: sdef = 1'b0;
        endcase
    end

    assign sg = bus.opcode == OP_MULH || bus.opcode == OP_MULL;
    assign ax = sg && bus.x[WIDTH-1] ? -bus.x : bus.x;
    assign ay = sg && bus.y[WIDTH-1] ? -bus.y : bus.y;
    assign go = bus.in_valid && st == IDLE && (smul || sdiv);

    seq_alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (go),
`ifdef SEQ_ALU_DIV_EN
        .div   (sdiv),
        .quo   (quo),
        .rem   (rem),
`endif
        .a     (ax),
        .b     (ay),
        .done  (done),
        .prod  (prod)
    );

    // multi-cycle completion: sign-correct the magnitude product and pick the requested half
    always_comb begin
        p  = neg_q ? -prod : prod;
        cr = (op_q == OP_MULH || op_q == OP_UMULH) ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
        cv = op_q == OP_MULL ? (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){p[WIDTH-1]}})
                             : (op_q == OP_UMULL && |p[2*WIDTH-1:WIDTH]);
`ifdef SEQ_ALU_DIV_EN
        if (op_q == OP_UDIV || op_q == OP_UREM) begin
            cr = op_q == OP_UDIV ? quo : rem;
            cv = yz_q;
        end
`endif
    end

    // control FSM; result and flags only change on entry to DONE, undefined opcodes keep the old flags
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            r_q   <= '0;
            fl_q  <= '0;
            ill_q <= 1'b0;
            op_q  <= OP_MOV;
            neg_q <= 1'b0;
        end else begin
            case (st)
                IDLE: if (bus.in_valid) begin
                    op_q  <= bus.opcode;
                    neg_q <= sg && (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
                    yz_q  <= bus.y == '0;
`endif
                    st    <= smul ? MUL : sdiv ? DIV : DONE;
                    if (!smul && !sdiv) begin
                        r_q   <= bus.opcode == OP_CMP ? '0 : sres;
                        fl_q  <= sdef ? '{n: sres[WIDTH-1], z: ~|sres, v: sv, c: sc} : fl_q;
                        ill_q <= !sdef;
                    end
                end
                MUL, DIV: if (done) begin
                    st    <= DONE;
                    r_q   <= cr;
                    fl_q  <= '{n: cr[WIDTH-1], z: ~|cr, v: cv, c: 1'b0};
                    ill_q <= 1'b0;
                end
                DONE: if (bus.out_ready) st <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = st == IDLE;
    assign bus.out_valid = st == DONE;
    assign bus.busy      = st == MUL || st == DIV;
    assign bus.r         = r_q;
    assign bus.negative  = fl_q.n;
    assign bus.zero      = fl_q.z;
    assign bus.overflow  = fl_q.v;
    assign bus.cout      = fl_q.c;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_seq_alu_v2.sv
// tb_seq_alu_v2: directed checks of seq_alu_v2 at WIDTH=16 (covers UDIV/UREM when SEQ_ALU_DIV_EN is defined)
module tb_seq_alu_v2;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int lat;
    int seen;
    logic rs, bs;

    seq_alu_v2_if #(.WIDTH(16)) bus ();
    seq_alu_v2 #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] fl();
        return {bus.negative, bus.zero, bus.overflow, bus.cout};
    endfunction

    // offer one operation, scramble the inputs after acceptance, wait (bounded) for out_valid
    task automatic run(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int l, output logic rdy, output logic bsy);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode = op;
        bus.x = a;
        bus.y = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode = 5'b01101;
        bus.x = ~a;
        bus.y = ~b;
        l = 1;
        rdy = 1'b0;
        bsy = 1'b0;
        while (!bus.out_valid && l < 40) begin
            rdy |= bus.in_ready;
            bsy |= bus.busy;
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic step(input string tag, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int elat, input logic [15:0] er, input logic [3:0] ef, input logic ei);
        run(op, a, b, lat, rs, bs);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_r"}, bus.r, er);
        chk({tag, "_flags"}, fl(), ef);
        chk({tag, "_illegal"}, bus.illegal, ei);
        if (elat > 1) chk({tag, "_wait_ready_busy"}, {rs, bs}, 2'b01);
        drain();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.opcode = 5'b0;
        bus.x = '0;
        bus.y = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.out_valid, bus.r, fl(), bus.illegal, bus.busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {bus.in_ready, bus.out_valid}, 2'b10);

        step("add_ovf",  OP_ADD,   16'h7FFF, 16'h0001, 1,  16'h8000, 4'b1010, 1'b0);
        step("undef",    5'b01101, 16'h1234, 16'h5678, 1,  16'h0000, 4'b1010, 1'b1);
        step("mull",     OP_MULL,  16'hFFFF, 16'h0003, 17, 16'hFFFD, 4'b1000, 1'b0);
        step("umulh",    OP_UMULH, 16'hFFFF, 16'h0003, 17, 16'h0002, 4'b0000, 1'b0);

        run(OP_SUB, 16'd5, 16'd5, lat, rs, bs);
        chk("sub_lat", lat, 1);
        chk("sub_r_flags", {bus.r, fl(), bus.illegal}, {16'h0, 4'b0101, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("sub_hold", {bus.out_valid, bus.in_ready, bus.r, fl()}, {2'b10, 16'h0, 4'b0101});
        end
        drain();
        chk("sub_drained", {bus.out_valid, bus.in_ready}, 2'b01);

        step("cmp",      OP_CMP,   16'd3,    16'd5,    1,  16'h0000, 4'b1000, 1'b0);
        step("lsl",      OP_LSL,   16'h8001, 16'h0011, 1,  16'h0002, 4'b0001, 1'b0);
        step("lsr0",     OP_LSR,   16'h0003, 16'h0010, 1,  16'h0003, 4'b0000, 1'b0);
        step("asr",      OP_ASR,   16'h8004, 16'h0003, 1,  16'hF000, 4'b1001, 1'b0);
        step("ror",      OP_ROR,   16'h0001, 16'h0001, 1,  16'h8000, 4'b1001, 1'b0);
        step("xor",      OP_XOR,   16'hF0F0, 16'hFFFF, 1,  16'h0F0F, 4'b0000, 1'b0);
        step("nand",     OP_NAND,  16'hFFFF, 16'hFFFF, 1,  16'h0000, 4'b0100, 1'b0);
        step("mull_ovf", OP_MULL,  16'h0100, 16'h0100, 17, 16'h0000, 4'b0110, 1'b0);
        step("umull",    OP_UMULL, 16'h00FF, 16'h0101, 17, 16'hFFFF, 4'b1000, 1'b0);
        step("mulh_pos", OP_MULH,  16'h8000, 16'h8000, 17, 16'h4000, 4'b0000, 1'b0);
        step("mulh_neg", OP_MULH,  16'hFFFE, 16'h0003, 17, 16'hFFFF, 4'b1000, 1'b0);
`ifdef SEQ_ALU_DIV_EN
        step("udiv",     OP_UDIV,  16'd100,  16'd7,    17, 16'd14,   4'b0000, 1'b0);
        step("urem",     OP_UREM,  16'd100,  16'd7,    17, 16'd2,    4'b0000, 1'b0);
        step("udiv0",    OP_UDIV,  16'h1234, 16'h0000, 17, 16'hFFFF, 4'b1010, 1'b0);
        step("urem0",    OP_UREM,  16'h1234, 16'h0000, 17, 16'h1234, 4'b0010, 1'b0);
`else
        step("udiv_undef", OP_UDIV, 16'd100, 16'd7,    1,  16'h0000, 4'b1000, 1'b1);
`endif

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode = OP_MULL;
        bus.x = 16'h1234;
        bus.y = 16'h0055;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_mul_busy", {bus.busy, bus.out_valid}, 2'b10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_mul_reset", {bus.out_valid, bus.r, fl(), bus.illegal, bus.busy, bus.in_ready}, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || bus.busy) seen++;
        end
        chk("abandoned_no_result", seen, 0);
        step("after_reset_add", OP_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 4'b0101, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu_v2.md
SEQ_ALU_V2 -- requirements
Module: seq_alu_v2

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width; legal values are even and from 8 to 32.
REQ-002 Port: clk  input  1  clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  operation offered.
REQ-005 Port: in_ready  output  1  operation accepted when in_valid and in_ready are both high.
REQ-006 Port: opcode  input  5  operation select.
REQ-007 Port: x, y  input  WIDTH each  operands; y also carries the shift count.
REQ-008 Port: out_valid  output  1  result r and the flags are valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: r  output  WIDTH  result.
REQ-011 Port: negative, zero, overflow, cout  output  1 each  registered condition flags (CPSR).
REQ-012 Port: illegal  output  1  the last completed opcode was undefined.
REQ-013 Port: busy  output  1  a multi-cycle operation is in progress.

Function
REQ-014 Opcodes SHALL be: 00000 MOV, 00001 ADD, 00010 SUB, 00011 MULH (signed), 00100 UMULH, 00101 CMP (signed, r=0), 00110 AND, 00111 OR, 01000 NOR, 01001 NAND, 01010 XOR, 01011 XNOR, 01100 NOT, 01111 MULL (signed), 10000 UMULL, 11000 LSR, 11001 LSL, 11010 ASR, 11100 ROR.
REQ-015 FSM states SHALL be IDLE, MUL, DIV and DONE.
- IDLE to DONE on acceptance of any single-cycle or undefined opcode.
- IDLE to MUL on acceptance of a multiply.
- MUL to DONE after WIDTH iteration cycles.
- DONE to IDLE when out_ready is high.
REQ-016 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-017 Latency, acceptance edge to out_valid: single-cycle ops SHALL take 1 cycle; multiplies SHALL take WIDTH+1 cycles.
REQ-018 r and all flags SHALL hold stable while out_valid is high and out_ready is low.
REQ-019 Multiply SHALL be iterative shift-add on operand magnitudes, one bit per cycle, producing a 2*WIDTH product. For signed ops the sign SHALL be corrected on entry to DONE. MULH/UMULH return the high half; MULL/UMULL return the low half.
REQ-020 ADD/SUB SHALL compute in WIDTH+1 bits.
- cout = carry out; for SUB, cout = NOT borrow.
- overflow = signed overflow.
- CMP SHALL compute flags as SUB does, with r=0.
REQ-021 Logic ops and MOV SHALL set overflow=0 and cout=0.
REQ-022 Multiplies SHALL set cout=0.
- MULL: overflow=1 when the signed product does not fit WIDTH bits.
- UMULL: overflow=1 when the high half is nonzero.
- MULH/UMULH: overflow=0.
REQ-023 Shift amount SHALL be y[clog2(WIDTH)-1:0].
- cout = last bit shifted out, or 0 when the amount is 0.
- ROR: cout = r[WIDTH-1].
- overflow=0.
REQ-024 For every op, negative = r[WIDTH-1] and zero = (r==0), except CMP, which uses the difference.
REQ-025 Undefined opcode: r=0, flags SHALL retain their previous values, illegal=1 for that result; every defined op SHALL clear illegal.
REQ-026 Flags SHALL update only on the transition into DONE and hold otherwise.
REQ-027 Operands and opcode SHALL be captured at acceptance; later changes to the inputs SHALL have no effect on the operation in flight.

Reset
REQ-028 When rst is high at a clock edge, the FSM SHALL go to IDLE.
- r, flags, illegal and out_valid SHALL clear to 0.
- Any multi-cycle operation in flight SHALL be abandoned and produce no result.
REQ-029 in_ready SHALL be high in the first cycle after rst deasserts.

Configuration
REQ-030 With macro SEQ_ALU_DIV_EN defined, the following SHALL be added:
- 10100 UDIV and 10101 UREM: restoring division, one bit per cycle, through the DIV state, latency WIDTH+1.
- Divide by zero: UDIV r = all-ones, UREM r = x, overflow=1; otherwise overflow=0, cout=0.
REQ-031 Without SEQ_ALU_DIV_EN, 10100 and 10101 SHALL behave as undefined opcodes and no divider logic SHALL exist.

Structure
REQ-032 Package seq_alu_pkg SHALL hold:
- the opcode localparams;
- the FSM state enum;
- the flags struct (N, Z, V, C).
REQ-033 Sub-module seq_alu_iter_unit SHALL hold the iterative multiply/divide datapath (shift registers and counter), with start/done signals to the FSM.

Verification (WIDTH=16)
REQ-034 ADD 0x7FFF+0x0001 -> r=0x8000, negative=1, overflow=1, cout=0, out_valid 1 cycle after acceptance.
REQ-035 MULL 0xFFFF*0x0003 -> r=0xFFFD, negative=1, overflow=0; UMULH of the same operands -> r=0x0002; out_valid 17 cycles after acceptance, in_ready low meanwhile.
REQ-036 SUB 5-5 with out_ready held low for 4 cycles -> r=0, zero=1, cout=1, values stable throughout, in_ready low until drained.
REQ-037 Opcode 01101 after ADD -> r=0, illegal=1, flags equal to the preceding ADD's flags.
REQ-038 rst asserted mid-MUL at cycle 8 -> next cycle IDLE, out_valid=0, all outputs 0, no result is ever delivered.
REQ-039 With SEQ_ALU_DIV_EN: UDIV 100/7 -> r=14; UREM 100/7 -> r=2; UDIV x/0 -> r=0xFFFF, overflow=1.
